// File: rtl/his_builder_pingpong.sv
// his_builder_pingpong
//   TDC-bin histogram builder with two ping-pong banks. Events are binned
//   into the accumulating bank; when a frame of ACQ_NUM acquisitions is
//   complete the banks swap, so the reader sees the finished frame while the
//   next one accumulates. Releasing the read bank clears it in the background.
//
// Optional feature macro: HIST_SAT_EN (bin counters saturate instead of wrap).
//
// Ports
//   clk, res          clock, asynchronous active-high reset
//   in_valid/in_ready event handshake; in_bin = TDC bin of the event
//   wr_bank           bank currently accumulating
//   frame_done        1-cycle pulse when the banks swap
//   rd_bank_valid     read bank holds a completed frame
//   rd_en/rd_addr     read request, address = pixel*NUM_BINS + bin
//   rd_data(_valid)   bin count, one cycle after rd_en
//   rd_release        pulse: reader done, clear the read bank
//   drop_err          sticky: an event with in_bin >= NUM_BINS was seen
//   dbg_state         current FSM state
//
// Handshake: an event transfers on a clock edge where in_valid && in_ready.
// in_ready depends only on the FSM state, never combinationally on in_valid.
module his_builder_pingpong #(
  parameter int BIN_W        = 5,
  parameter int NUM_BINS     = 32,
  parameter int PIXELS       = 200,
  parameter int DATA_PER_PIX = 2,
  parameter int ACQ_NUM      = 33333,
  parameter int CNT_W        = 16,
  parameter int ADDR_W       = 13
) (
  input  logic              clk,
  input  logic              res,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BIN_W-1:0]  in_bin,
  output logic              wr_bank,
  output logic              frame_done,
  output logic              rd_bank_valid,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_data_valid,
  input  logic              rd_release,
  output logic              drop_err,
  output logic [2:0]        dbg_state
);

  localparam int DEPTH = PIXELS * NUM_BINS;
  localparam int EVT_W = (DATA_PER_PIX > 1) ? $clog2(DATA_PER_PIX) : 1;
  localparam int PIX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int ACQ_W = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;

  typedef enum logic [2:0] {
    ST_INIT_CLR  = 3'd0,
    ST_ACCUM     = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_WAIT_FREE = 3'd3,
    ST_SWAP      = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic [EVT_W-1:0]  r_evt;
  logic [PIX_W-1:0]  r_pix;
  logic [ACQ_W-1:0]  r_acq;
  logic [ADDR_W-1:0] r_sweep_addr;
  logic              r_bg_busy, r_rd_bank_valid, r_wr_bank, r_frame_done, r_drop_err;
  logic              r_s0_valid, r_s1_valid;
  logic [ADDR_W-1:0] r_s0_addr, r_s1_addr;
  logic [CNT_W-1:0]  r_s1_data, r_rd_data;
  logic              r_rd_data_valid;
  logic [CNT_W-1:0]  r_mem0 [DEPTH];
  logic [CNT_W-1:0]  r_mem1 [DEPTH];

  logic              w_in_ready, w_accept, w_in_range, w_frame_end;
  logic              w_evt_last, w_pix_last, w_acq_last, w_sweep_last, w_bank_free;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [CNT_W-1:0]  w_s0_mem, w_s0_rd, w_s1_sum;
  logic              w_we0, w_we1;
  logic [ADDR_W-1:0] w_wa0, w_wa1;
  logic [CNT_W-1:0]  w_wd0, w_wd1;

  assign w_accept     = in_valid && w_in_ready;
  assign w_in_range   = 32'(in_bin) < NUM_BINS;
  assign w_evt_last   = (r_evt == EVT_W'(DATA_PER_PIX - 1));
  assign w_pix_last   = (r_pix == PIX_W'(PIXELS - 1));
  assign w_acq_last   = (r_acq == ACQ_W'(ACQ_NUM - 1));
  assign w_frame_end  = w_accept && w_evt_last && w_pix_last && w_acq_last;
  assign w_sweep_last = (r_sweep_addr == ADDR_W'(DEPTH - 1));
  assign w_bank_free  = !r_rd_bank_valid && !r_bg_busy;
  assign w_wr_addr    = ADDR_W'(r_pix) * ADDR_W'(NUM_BINS) + ADDR_W'(in_bin);

  // Event counters: evt -> pix -> acq, each carrying into the next.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_evt <= '0;
      r_pix <= '0;
      r_acq <= '0;
    end else if (w_accept) begin
      if (w_evt_last) begin
        r_evt <= '0;
        if (w_pix_last) begin
          r_pix <= '0;
          r_acq <= w_acq_last ? '0 : r_acq + 1'b1;
        end else begin
          r_pix <= r_pix + 1'b1;
        end
      end else begin
        r_evt <= r_evt + 1'b1;
      end
    end
  end

  // Update pipeline. Out-of-range events never enter it. S0 reads the
  // accumulating bank; if S1 is about to write the same address, its result
  // is forwarded so back-to-back hits on one bin are not lost.
  assign w_s0_mem = r_wr_bank ? r_mem1[r_s0_addr] : r_mem0[r_s0_addr];
  assign w_s0_rd  = (r_s1_valid && (r_s1_addr == r_s0_addr)) ? w_s1_sum : w_s0_mem;

`ifdef HIST_SAT_EN
  assign w_s1_sum = (&r_s1_data) ? r_s1_data : r_s1_data + CNT_W'(1);
`else
  assign w_s1_sum = r_s1_data + CNT_W'(1);
`endif

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_s0_valid <= 1'b0;
      r_s0_addr  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_data  <= '0;
    end else begin
      r_s0_valid <= w_accept && w_in_range;
      if (w_accept && w_in_range) r_s0_addr <= w_wr_addr;
      r_s1_valid <= r_s0_valid;
      r_s1_addr  <= r_s0_addr;
      r_s1_data  <= w_s0_rd;
    end
  end

  // Bank write ports. S1 always targets the accumulating bank and the
  // background sweep always targets the read bank, so they never collide.
  always_comb begin
    w_we0 = 1'b0;
    w_we1 = 1'b0;
    w_wa0 = r_sweep_addr;
    w_wa1 = r_sweep_addr;
    w_wd0 = '0;
    w_wd1 = '0;
    if (r_state == ST_INIT_CLR) begin
      w_we0 = 1'b1;
      w_we1 = 1'b1;
    end else begin
      if (r_s1_valid) begin
        if (r_wr_bank) begin
          w_we1 = 1'b1;
          w_wa1 = r_s1_addr;
          w_wd1 = w_s1_sum;
        end else begin
          w_we0 = 1'b1;
          w_wa0 = r_s1_addr;
          w_wd0 = w_s1_sum;
        end
      end
      if (r_bg_busy) begin
        if (r_wr_bank) w_we0 = 1'b1;
        else           w_we1 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we0) r_mem0[w_wa0] <= w_wd0;
    if (w_we1) r_mem1[w_wa1] <= w_wd1;
  end

  // Bank ownership, background clear and status flags.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_sweep_addr    <= '0;
      r_bg_busy       <= 1'b0;
      r_rd_bank_valid <= 1'b0;
      r_wr_bank       <= 1'b0;
      r_frame_done    <= 1'b0;
      r_drop_err      <= 1'b0;
    end else begin
      r_frame_done <= (r_state == ST_SWAP);
      if (r_state == ST_SWAP) begin
        r_wr_bank       <= ~r_wr_bank;
        r_rd_bank_valid <= 1'b1;
      end else if (rd_release && r_rd_bank_valid && !r_bg_busy) begin
        r_rd_bank_valid <= 1'b0;
        r_bg_busy       <= 1'b1;
      end
      // The sweep address returns to 0 at the end of every sweep, so a new
      // background clear always starts from address 0.
      if ((r_state == ST_INIT_CLR) || r_bg_busy) begin
        r_sweep_addr <= w_sweep_last ? '0 : r_sweep_addr + 1'b1;
        if (w_sweep_last) r_bg_busy <= 1'b0;
      end
      if (w_accept && !w_in_range) r_drop_err <= 1'b1;
    end
  end

  // Read port on the bank not being accumulated.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_rd_data       <= '0;
      r_rd_data_valid <= 1'b0;
    end else if (rd_en && r_rd_bank_valid) begin
      r_rd_data       <= r_wr_bank ? r_mem0[rd_addr] : r_mem1[rd_addr];
      r_rd_data_valid <= 1'b1;
    end else begin
      r_rd_data       <= '0;
      r_rd_data_valid <= 1'b0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge res) begin
    if (res) r_state <= ST_INIT_CLR;
    else     r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT_CLR:  if (w_sweep_last) w_next = ST_ACCUM;
      ST_ACCUM:     if (w_frame_end) w_next = ST_DRAIN;
      ST_DRAIN:     if (!r_s0_valid && !r_s1_valid)
                      w_next = w_bank_free ? ST_SWAP : ST_WAIT_FREE;
      ST_WAIT_FREE: if (w_bank_free) w_next = ST_SWAP;
      ST_SWAP:      w_next = ST_ACCUM;
      default:      w_next = ST_INIT_CLR;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_in_ready = (r_state == ST_ACCUM);
    dbg_state  = r_state;
  end

  assign in_ready      = w_in_ready;
  assign wr_bank       = r_wr_bank;
  assign frame_done    = r_frame_done;
  assign rd_bank_valid = r_rd_bank_valid;
  assign rd_data       = r_rd_data;
  assign rd_data_valid = r_rd_data_valid;
  assign drop_err      = r_drop_err;

endmodule
